// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, fetch states.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    VALID
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection: sequential, PC-relative branch, or pseudo-direct jump.
module next_pc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              branch,
  input  logic              jump,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] p4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] jmp_addr;

  assign p4     = pc + ADDR_W'(PC_STEP);
  assign br_off = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};

  // Jump keeps the region bits of pc+4 above the 28-bit target window.
  generate
    if (ADDR_W > 28) begin : g_jmp_region
      assign jmp_addr = {p4[ADDR_W-1:28], target, 2'b00};
    end else begin : g_jmp_flat
      assign jmp_addr = {target, 2'b00};
    end
  endgenerate

  always_comb begin
    next_addr = p4;
    if (jump) begin
      next_addr = jmp_addr;
    end else if (branch) begin
      next_addr = p4 + br_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack, hands split fields to the decoder.
// Optional FETCH_PERF_CNT_EN adds fetch_count/redirect_count outputs.
//
// state | meaning
// IDLE  | one bubble after reset, no request
// REQ   | imem_req high at pc, waiting for imem_ack
// VALID | instruction held, fields valid until instr_accept
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_accept,
  input  logic              branch,
  input  logic              jump,
  output logic [5:0]        op,
  output logic [5:0]        func,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [15:0]       imm,
  output logic [25:0]       target,
  output logic [ADDR_W-1:0] pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       redirect_count
`endif
);

  fetch_state_t      state;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] pc_next;

  assign op        = instr[OP_MSB:OP_LSB];
  assign rs        = instr[RS_MSB:RS_LSB];
  assign rt        = instr[RT_MSB:RT_LSB];
  assign rd        = instr[RD_MSB:RD_LSB];
  assign shamt     = instr[SHAMT_MSB:SHAMT_LSB];
  assign func      = instr[FUNC_MSB:FUNC_LSB];
  assign imm       = instr[IMM_MSB:IMM_LSB];
  assign target    = instr[TARGET_MSB:TARGET_LSB];
  assign imem_addr = pc;

  next_pc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .pc       (pc),
    .imm      (imm),
    .target   (target),
    .branch   (branch),
    .jump     (jump),
    .next_addr(pc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            state       <= VALID;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        VALID: begin
          if (instr_accept) begin
            pc          <= pc_next;
            state       <= REQ;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else if (state == VALID && instr_accept) begin
      fetch_count <= fetch_count + 32'd1;
      if (branch || jump) begin
        redirect_count <= redirect_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a behavioural model.
module tb_fetch_unit;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [31:0]       imem_rdata = '0;
  logic              instr_valid;
  logic              instr_accept = 1'b0;
  logic              branch = 1'b0;
  logic              jump = 1'b0;
  logic [5:0]        op;
  logic [5:0]        func;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic [ADDR_W-1:0] pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       fetch_count;
  logic [31:0]       redirect_count;
`endif

  int tests = 0;
  int fails = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_accept(instr_accept),
    .branch      (branch),
    .jump        (jump),
    .op          (op),
    .func        (func),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .imm         (imm),
    .target      (target),
    .pc          (pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .redirect_count(redirect_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch stage is holding, in spec terms.
  logic        m_seen_rst = 1'b0;
  logic        m_req = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_fetches = '0;
  logic [31:0] m_redirects = '0;

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                           input logic br, input logic jp);
    logic [31:0] p4;
    int          off;
    p4  = cur + 32'd4;
    off = $signed(w[15:0]);
    if (jp) return (p4 & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
    if (br) return p4 + 32'(off * 4);
    return p4;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_seen_rst  = 1'b1;
      m_pc        = '0;
      m_instr     = '0;
      m_req       = 1'b0;
      m_valid     = 1'b0;
      m_fetches   = '0;
      m_redirects = '0;
    end else if (m_valid) begin
      if (instr_accept) begin
        m_pc      = ref_next(m_pc, m_instr, branch, jump);
        m_fetches = m_fetches + 1;
        if (branch || jump) m_redirects = m_redirects + 1;
        m_valid   = 1'b0;
        m_req     = 1'b1;
      end
    end else if (m_req) begin
      if (imem_ack) begin
        m_instr = imem_rdata;
        m_req   = 1'b0;
        m_valid = 1'b1;
      end
    end else begin
      m_req = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_seen_rst) begin
      chk("imem_req", 32'(imem_req), 32'(m_req));
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("op", 32'(op), 32'(m_instr[31:26]));
      chk("rs", 32'(rs), 32'(m_instr[25:21]));
      chk("rt", 32'(rt), 32'(m_instr[20:16]));
      chk("rd", 32'(rd), 32'(m_instr[15:11]));
      chk("shamt", 32'(shamt), 32'(m_instr[10:6]));
      chk("func", 32'(func), 32'(m_instr[5:0]));
      chk("imm", 32'(imm), 32'(m_instr[15:0]));
      chk("target", 32'(target), 32'(m_instr[25:0]));
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, m_fetches);
      chk("redirect_count", redirect_count, m_redirects);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ends in REQ at pc 0 after checking the reset-state outputs.
  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    instr_accept = 1'b0;
    branch = 1'b0;
    jump = 1'b0;
    step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_target", 32'(target), 32'd0);
    rst = 1'b0;
    step();
    chk("bubble_req", 32'(imem_req), 32'd1);
    chk("bubble_addr", imem_addr, 32'd0);
  endtask

  // From REQ: zero-wait fetch of w, accept with the given redirect, back in REQ.
  task automatic fetch_accept(input logic [31:0] w, input logic br, input logic jp);
    imem_ack = 1'b1;
    imem_rdata = w;
    step();
    chk("fa_valid", 32'(instr_valid), 32'd1);
    imem_ack = 1'b0;
    instr_accept = 1'b1;
    branch = br;
    jump = jp;
    step();
    chk("fa_req", 32'(imem_req), 32'd1);
    instr_accept = 1'b0;
    branch = 1'b0;
    jump = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] seq_exp [3];
    seq_exp[0] = 32'h8;
    seq_exp[1] = 32'hC;
    seq_exp[2] = 32'h10;

    do_reset();
    imem_ack = 1'b1;
    imem_rdata = 32'h8C22_0004;
    step();
    imem_ack = 1'b0;
    chk("lw_valid", 32'(instr_valid), 32'd1);
    chk("lw_op", 32'(op), 32'h23);
    chk("lw_rs", 32'(rs), 32'd1);
    chk("lw_rt", 32'(rt), 32'd2);
    chk("lw_imm", 32'(imm), 32'd4);

    instr_accept = 1'b1;
    step();
    instr_accept = 1'b0;
    chk("seq_addr4", imem_addr, 32'h4);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      fetch_accept(w, 1'b0, 1'b0);
      chk("seq_addr", imem_addr, seq_exp[i]);
    end

    fetch_accept(32'h1022_FFFE, 1'b1, 1'b0);
    chk("branch_back", imem_addr, 32'h0C);

    do_reset();
    for (int i = 0; i < 4; i++) fetch_accept($urandom, 1'b0, 1'b0);
    chk("walk_0x10", imem_addr, 32'h10);
    fetch_accept({6'h02, 26'h40}, 1'b0, 1'b1);
    chk("jump_addr", imem_addr, 32'h100);

    do_reset();
    for (int i = 0; i < 4; i++) fetch_accept($urandom, 1'b0, 1'b0);
    fetch_accept({6'h02, 26'h40}, 1'b1, 1'b1);
    chk("jump_over_branch", imem_addr, 32'h100);

    w = $urandom;
    imem_ack = 1'b1;
    imem_rdata = w;
    step();
    for (int i = 0; i < 5; i++) begin
      imem_ack = (i >= 2);
      imem_rdata = ~w;
      step();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_op", 32'(op), 32'(w[31:26]));
      chk("stall_imm", 32'(imm), 32'(w[15:0]));
      chk("stall_target", 32'(target), 32'(w[25:0]));
    end
    imem_ack = 1'b0;
    instr_accept = 1'b1;
    step();
    instr_accept = 1'b0;

    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = $urandom;
    step();
    chk("late_ack_req", 32'(imem_req), 32'd1);
    chk("late_ack_valid", 32'(instr_valid), 32'd0);
    chk("late_ack_addr", imem_addr, 32'd0);
    imem_ack = 1'b0;
    step();
    chk("late_ack_still", 32'(instr_valid), 32'd0);

    fetch_accept(32'h1022_FFFE, 1'b1, 1'b0);
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    fetch_accept($urandom, 1'b0, 1'b0);
    chk("wrap_zero", imem_addr, 32'h0);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      imem_ack = $urandom_range(0, 1);
      imem_rdata = $urandom;
      instr_accept = $urandom_range(0, 1);
      branch = ($urandom_range(0, 3) == 0);
      jump = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle instruction decoder.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Holds the returned word and presents split fields (op, func, rs, rt, rd, shamt, imm, target) to the decoder with a valid/accept handshake.
- Consumes the decoder's branch and jump outputs at accept time to select the next PC.

Parameters:
- ADDR_W, 32, PC and instruction-address width (≥ 28).
- RESET_PC, 0, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- imem_req  out  1  fetch request pending
- imem_addr  out  ADDR_W  word-aligned fetch address (equals pc)
- imem_ack  in  1  instruction-memory response valid; honoured only while imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_ack
- instr_valid  out  1  fields below are valid
- instr_accept  in  1  decoder/execute consumes current instruction
- branch  in  1  decoder branch-taken, sampled on accept
- jump  in  1  decoder jump, sampled on accept
- op  out  6  instr[31:26]
- func  out  6  instr[5:0]
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
- shamt  out  5  instr[10:6]
- imm  out  16  instr[15:0]
- target  out  26  instr[25:0]
- pc  out  ADDR_W  address of the held or in-flight instruction

Behaviour:
- One clock; reset is synchronous and active-high.
- FSM states: IDLE, REQ, VALID.
- Reset values:
  - State IDLE, pc=RESET_PC.
  - Instruction register 0, so all fields are 0.
  - imem_req=0, instr_valid=0.
- IDLE: next cycle go to REQ (one bubble after reset).
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: latch imem_rdata into the instruction register and go to VALID.
  - Latency: ack in cycle N gives instr_valid=1 from cycle N+1.
  - With zero-wait memory (ack in the same cycle as req), an instruction issues every 2 cycles when accept is tied high.
- VALID:
  - instr_valid=1, imem_req=0.
  - Fields are driven combinationally from the instruction register and stay stable until accept.
  - On instr_accept, update pc, clear instr_valid and go to REQ.
- Next-PC rule on accept (p4 = pc+4):
  - jump=1: pc <= {p4[ADDR_W-1:28], target, 2'b00}. Jump has priority over branch when both are high.
  - branch=1 and jump=0: pc <= p4 + (sign_extend(imm) << 2).
  - Otherwise: pc <= p4.
- Arithmetic: all modulo 2^ADDR_W. PC wraps silently from max to 0; no fault.
- branch and jump are ignored outside VALID+accept.
- instr_accept outside VALID is ignored.
- imem_ack outside REQ is ignored; no latch, no state change.
- Reset mid-REQ: abandons the request. imem_req drops next cycle. A late ack for the abandoned request arrives in IDLE and is ignored per the rule above.
- Reset mid-VALID: instruction discarded, instr_valid=0 next cycle.
- Reset has priority over all other inputs.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs fetch_count [31:0] and redirect_count [31:0].
  - fetch_count increments on each accepted instruction.
  - redirect_count increments on accepts with branch|jump=1.
  - Both are 0 on reset and wrap at 2^32.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J.
  - Instruction field bit-position constants.
  - fetch_state_t enum {IDLE, REQ, VALID}.
  - Constant PC_STEP=4.
- One natural sub-module: next_pc. Purely combinational, taking pc, imm, target, branch and jump and returning the new PC. It is reusable and separately testable.

Test Plan:
- Reset, then ack with rdata=32'h8C220004 (lw) in the first REQ cycle:
  - imem_addr=0.
  - Next cycle instr_valid=1, op=6'b100011, rs=1, rt=2, imm=4.
- Sequential fetch with accept held high and zero-wait memory:
  - pc steps 0, 4, 8, 0xC.
  - One instruction per 2 cycles.
- Redirects, each on accept:
  - pc=0x10, imm=16'hFFFE, branch=1: next imem_addr=0x0C.
  - pc=0x10, jump=1, target=26'h40: next imem_addr=0x100.
  - Both branch and jump high: jump target is used.
- Stalls and stray inputs:
  - instr_accept held low for 5 cycles: fields and instr_valid stay stable, imem_req=0.
  - Stray ack in VALID: no change.
- Reset during REQ with ack asserted in the following cycle:
  - Ack ignored; state IDLE, then REQ.
  - imem_addr=RESET_PC, instr_valid stays 0.
- Wrap: pc=32'hFFFFFFFC, accept with no redirect → next imem_addr=0.
